// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS BCD time-of-day counter.
// Contents:
//   field_e          adjust field selector encoding (sec/min/hour/none)
//   bcd_time_t       packed layout of the 20-bit parallel load word
//   HOUR_MODE_*      legal values of the HOUR_MODE parameter
//   *_MAX / *_MIN    numeric limits of each time field
//   load_time_valid  range/BCD check applied to a parallel load word
package clock_pkg;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2,
    FIELD_NONE = 2'd3
  } field_e;

  localparam int HOUR_MODE_12 = 32'sd12;
  localparam int HOUR_MODE_24 = 32'sd24;

  localparam int SEC_MIN_MAX  = 32'sd59;
  localparam int HOUR24_MAX   = 32'sd23;
  localparam int HOUR12_MIN   = 32'sd1;
  localparam int HOUR12_MAX   = 32'sd12;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [2:0] BCD_TENS_MAX  = 3'd5;

  typedef struct packed {
    logic [1:0] tens_hour;
    logic [3:0] units_hour;
    logic [2:0] tens_min;
    logic [3:0] units_min;
    logic [2:0] tens_sec;
    logic [3:0] units_sec;
  } bcd_time_t;

  // A load word is usable only if every digit is a legal BCD digit for its
  // position and the hour lies in the range of the active hour mode.
  function automatic logic load_time_valid(input bcd_time_t t, input logic mode12);
    logic       digits_ok;
    logic       hour_ok;
    logic [5:0] hour_v;
    digits_ok = (t.units_hour <= BCD_DIGIT_MAX) &&
                (t.tens_min   <= BCD_TENS_MAX)  &&
                (t.units_min  <= BCD_DIGIT_MAX) &&
                (t.tens_sec   <= BCD_TENS_MAX)  &&
                (t.units_sec  <= BCD_DIGIT_MAX);
    hour_v = ({4'd0, t.tens_hour} * 6'd10) + {2'd0, t.units_hour};
    if (mode12) begin
      hour_ok = (hour_v >= 6'd1) && (hour_v <= 6'd12);
    end else begin
      hour_ok = (hour_v <= 6'd23);
    end
    return digits_ok && hour_ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter covering MIN_VAL..MAX_VAL inclusive.
// Incrementing past MAX_VAL wraps to MIN_VAL, decrementing below MIN_VAL
// wraps to MAX_VAL. Load has priority over inc, inc over dec.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset to RST_VAL
//   inc_i/dec_i    step up / down by one
//   load_i         parallel load of load_units_i/load_tens_i
//   units_o/tens_o registered BCD digits
//   carry_o        combinational: an increment is wrapping MAX_VAL->MIN_VAL
//   borrow_o       combinational: a decrement is wrapping MIN_VAL->MAX_VAL
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MIN_VAL = 32'sd0,
  parameter int MAX_VAL = 32'sd59,
  parameter int RST_VAL = 32'sd0,
  parameter int TENS_W  = 32'sd3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              load_i,
  input  logic [3:0]        load_units_i,
  input  logic [TENS_W-1:0] load_tens_i,
  output logic [3:0]        units_o,
  output logic [TENS_W-1:0] tens_o,
  output logic              carry_o,
  output logic              borrow_o
);

  localparam logic [3:0]        MIN_U = 4'(MIN_VAL % 10);
  localparam logic [TENS_W-1:0] MIN_T = TENS_W'(MIN_VAL / 10);
  localparam logic [3:0]        MAX_U = 4'(MAX_VAL % 10);
  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_VAL / 10);
  localparam logic [3:0]        RST_U = 4'(RST_VAL % 10);
  localparam logic [TENS_W-1:0] RST_T = TENS_W'(RST_VAL / 10);
  localparam logic [TENS_W-1:0] TENS_ONE = TENS_W'(1);

  logic [3:0]        units_q, units_d;
  logic [TENS_W-1:0] tens_q, tens_d;
  logic              at_max_s, at_min_s;

  assign at_max_s = (units_q == MAX_U) && (tens_q == MAX_T);
  assign at_min_s = (units_q == MIN_U) && (tens_q == MIN_T);

  assign carry_o  = inc_i && !load_i && at_max_s;
  assign borrow_o = dec_i && !load_i && !inc_i && at_min_s;

  assign units_o = units_q;
  assign tens_o  = tens_q;

  // Next-state: load, else modulo step up, else modulo step down, else hold.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (load_i) begin
      units_d = load_units_i;
      tens_d  = load_tens_i;
    end else if (inc_i) begin
      if (at_max_s) begin
        units_d = MIN_U;
        tens_d  = MIN_T;
      end else if (units_q == BCD_DIGIT_MAX) begin
        units_d = 4'd0;
        tens_d  = tens_q + TENS_ONE;
      end else begin
        units_d = units_q + 4'd1;
      end
    end else if (dec_i) begin
      if (at_min_s) begin
        units_d = MAX_U;
        tens_d  = MAX_T;
      end else if (units_q == 4'd0) begin
        units_d = BCD_DIGIT_MAX;
        tens_d  = tens_q - TENS_ONE;
      end else begin
        units_d = units_q - 4'd1;
      end
    end else begin
      units_d = units_q;
      tens_d  = tens_q;
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      units_q <= RST_U;
      tens_q  <= RST_T;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

endmodule

// File: rtl/clock_counters_param.sv
// HH:MM:SS BCD time-of-day counter with an internal 1 Hz prescaler,
// selectable 12/24-hour mode, per-field adjust and validated parallel load.
// Ports:
//   i_Clock, i_Reset          clock, synchronous active-high reset
//   i_Run                     enables the prescaler (time advances on ticks)
//   i_Adjust_Valid/_Field/_Down  one-cycle +/-1 on sec, min or hour (no carry)
//   i_Load, i_Load_Time, i_Load_PM  one-cycle parallel time load
//   o_Units_*/o_Tens_*        registered BCD time digits
//   o_PM                      PM flag (always 0 in 24-hour mode)
//   o_Tick                    pulse when the seconds advance from the prescaler
//   o_Day_Wrap                pulse when the time rolls into the next day
//   o_Load_Error              pulse when a load word is rejected
// Per-cycle priority is reset > load > adjust > tick; the losers are dropped.
module clock_counters_param
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 32'sd100_000_000,
  parameter int HOUR_MODE = 32'sd24
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Run,
  input  logic        i_Adjust_Valid,
  input  logic [1:0]  i_Adjust_Field,
  input  logic        i_Adjust_Down,
  input  logic        i_Load,
  input  logic [19:0] i_Load_Time,
  input  logic        i_Load_PM,
  output logic [3:0]  o_Units_Sec,
  output logic [2:0]  o_Tens_Sec,
  output logic [3:0]  o_Units_Min,
  output logic [2:0]  o_Tens_Min,
  output logic [3:0]  o_Units_Hour,
  output logic [1:0]  o_Tens_Hour,
  output logic        o_PM,
  output logic        o_Tick,
  output logic        o_Day_Wrap,
  output logic        o_Load_Error
);

  localparam logic MODE12  = (HOUR_MODE == HOUR_MODE_12);
  localparam int   PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  // 12-hour display runs 12,01..11 and comes out of reset at 12.
  localparam int HOUR_MIN_V = MODE12 ? HOUR12_MIN : 32'sd0;
  localparam int HOUR_MAX_V = MODE12 ? HOUR12_MAX : HOUR24_MAX;
  localparam int HOUR_RST_V = MODE12 ? HOUR12_MAX : 32'sd0;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pm_q, pm_d;
  logic               tick_q, tick_d;
  logic               day_wrap_q, day_wrap_d;
  logic               load_err_q, load_err_d;

  bcd_time_t load_time_s;
  field_e    adj_field_s;
  logic      load_ok_s;
  logic      tick_due_s;
  logic      load_apply_s, load_reject_s, adj_apply_s, tick_apply_s;

  logic sec_inc_s, sec_dec_s, min_inc_s, min_dec_s, hour_inc_s, hour_dec_s;
  logic sec_carry_s, min_carry_s, hour_carry_s;
  logic sec_borrow_unused_s, min_borrow_unused_s, hour_borrow_unused_s;
  logic hour_is_11_s, pm_flip_s;

  assign load_time_s = bcd_time_t'(i_Load_Time);
  assign adj_field_s = field_e'(i_Adjust_Field);
  assign load_ok_s   = load_time_valid(load_time_s, MODE12);
  assign tick_due_s  = i_Run && (presc_q == PRESC_LAST);

  // Event arbitration: exactly one of load / adjust / tick acts per cycle.
  // An adjust of field 3 is a pure no-op and does not block the tick.
  always_comb begin
    load_apply_s  = 1'b0;
    load_reject_s = 1'b0;
    adj_apply_s   = 1'b0;
    tick_apply_s  = 1'b0;
    if (i_Load) begin
      if (load_ok_s) begin
        load_apply_s = 1'b1;
      end else begin
        load_reject_s = 1'b1;
      end
    end else if (i_Adjust_Valid && (adj_field_s != FIELD_NONE)) begin
      adj_apply_s = 1'b1;
    end else if (tick_due_s) begin
      tick_apply_s = 1'b1;
    end else begin
      tick_apply_s = 1'b0;
    end
  end

  // Carries only ripple on a tick; adjust steps never reach a neighbour field.
  assign sec_inc_s  = tick_apply_s ||
                      (adj_apply_s && (adj_field_s == FIELD_SEC) && !i_Adjust_Down);
  assign sec_dec_s  = adj_apply_s && (adj_field_s == FIELD_SEC) && i_Adjust_Down;
  assign min_inc_s  = (tick_apply_s && sec_carry_s) ||
                      (adj_apply_s && (adj_field_s == FIELD_MIN) && !i_Adjust_Down);
  assign min_dec_s  = adj_apply_s && (adj_field_s == FIELD_MIN) && i_Adjust_Down;
  assign hour_inc_s = (tick_apply_s && min_carry_s) ||
                      (adj_apply_s && (adj_field_s == FIELD_HOUR) && !i_Adjust_Down);
  assign hour_dec_s = adj_apply_s && (adj_field_s == FIELD_HOUR) && i_Adjust_Down;

  // In 12-hour mode the meridiem flips when a tick carries 11:59:59 into 12.
  assign hour_is_11_s = (o_Tens_Hour == 2'd1) && (o_Units_Hour == 4'd1);
  assign pm_flip_s    = MODE12 && tick_apply_s && min_carry_s && hour_is_11_s;

  bcd_mod_counter #(
    .MIN_VAL (32'sd0),
    .MAX_VAL (SEC_MIN_MAX),
    .RST_VAL (32'sd0),
    .TENS_W  (32'sd3)
  ) u_sec (
    .clk_i        (i_Clock),
    .rst_i        (i_Reset),
    .inc_i        (sec_inc_s),
    .dec_i        (sec_dec_s),
    .load_i       (load_apply_s),
    .load_units_i (load_time_s.units_sec),
    .load_tens_i  (load_time_s.tens_sec),
    .units_o      (o_Units_Sec),
    .tens_o       (o_Tens_Sec),
    .carry_o      (sec_carry_s),
    .borrow_o     (sec_borrow_unused_s)
  );

  bcd_mod_counter #(
    .MIN_VAL (32'sd0),
    .MAX_VAL (SEC_MIN_MAX),
    .RST_VAL (32'sd0),
    .TENS_W  (32'sd3)
  ) u_min (
    .clk_i        (i_Clock),
    .rst_i        (i_Reset),
    .inc_i        (min_inc_s),
    .dec_i        (min_dec_s),
    .load_i       (load_apply_s),
    .load_units_i (load_time_s.units_min),
    .load_tens_i  (load_time_s.tens_min),
    .units_o      (o_Units_Min),
    .tens_o       (o_Tens_Min),
    .carry_o      (min_carry_s),
    .borrow_o     (min_borrow_unused_s)
  );

  bcd_mod_counter #(
    .MIN_VAL (HOUR_MIN_V),
    .MAX_VAL (HOUR_MAX_V),
    .RST_VAL (HOUR_RST_V),
    .TENS_W  (32'sd2)
  ) u_hour (
    .clk_i        (i_Clock),
    .rst_i        (i_Reset),
    .inc_i        (hour_inc_s),
    .dec_i        (hour_dec_s),
    .load_i       (load_apply_s),
    .load_units_i (load_time_s.units_hour),
    .load_tens_i  (load_time_s.tens_hour),
    .units_o      (o_Units_Hour),
    .tens_o       (o_Tens_Hour),
    .carry_o      (hour_carry_s),
    .borrow_o     (hour_borrow_unused_s)
  );

  // Prescaler: restarts on an accepted load or a seconds adjust, holds on a
  // rejected load and while stopped, otherwise counts 0..TICK_DIV-1.
  always_comb begin
    presc_d = presc_q;
    if (i_Load) begin
      if (load_ok_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q;
      end
    end else if (adj_apply_s && (adj_field_s == FIELD_SEC)) begin
      presc_d = '0;
    end else if (i_Run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Meridiem flag: loaded, toggled at the 11->12 rollover, fixed 0 in 24h.
  always_comb begin
    pm_d = pm_q;
    if (!MODE12) begin
      pm_d = 1'b0;
    end else if (load_apply_s) begin
      pm_d = i_Load_PM;
    end else if (pm_flip_s) begin
      pm_d = ~pm_q;
    end else begin
      pm_d = pm_q;
    end
  end

  // Strobes: the day wraps at 23:59:59 in 24h, or on the PM->AM flip in 12h.
  always_comb begin
    tick_d     = tick_apply_s;
    load_err_d = load_reject_s;
    if (MODE12) begin
      day_wrap_d = pm_flip_s && pm_q;
    end else begin
      day_wrap_d = tick_apply_s && hour_carry_s;
    end
  end

  // Prescaler, meridiem and strobe registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      presc_q    <= '0;
      pm_q       <= 1'b0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pm_q       <= pm_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign o_PM         = pm_q;
  assign o_Tick       = tick_q;
  assign o_Day_Wrap   = day_wrap_q;
  assign o_Load_Error = load_err_q;

endmodule

// File: tb/tb_clock_counters_param.sv
// Bench for clock_counters_param: a 24h and a 12h instance share one stimulus
// bus. A directed vector table checks hand-derived values, then random
// stimulus is checked every cycle against a seconds-of-day reference model.
module tb_clock_counters_param;

  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, adj, dn, ld, lpm;
  logic [1:0]  fld;
  logic [19:0] lt;

  logic [3:0] us24, um24, uh24, us12, um12, uh12;
  logic [2:0] ts24, tm24, ts12, tm12;
  logic [1:0] th24, th12;
  logic       pm24, tk24, wr24, er24, pm12, tk12, wr12, er12;
  logic [23:0] got24, got12;

  assign got24 = {th24, uh24, tm24, um24, ts24, us24, pm24, tk24, wr24, er24};
  assign got12 = {th12, uh12, tm12, um12, ts12, us12, pm12, tk12, wr12, er12};

  clock_counters_param #(.TICK_DIV(TD), .HOUR_MODE(24)) u_dut24 (
    .i_Clock(clk), .i_Reset(rst), .i_Run(run), .i_Adjust_Valid(adj),
    .i_Adjust_Field(fld), .i_Adjust_Down(dn), .i_Load(ld), .i_Load_Time(lt),
    .i_Load_PM(lpm), .o_Units_Sec(us24), .o_Tens_Sec(ts24), .o_Units_Min(um24),
    .o_Tens_Min(tm24), .o_Units_Hour(uh24), .o_Tens_Hour(th24), .o_PM(pm24),
    .o_Tick(tk24), .o_Day_Wrap(wr24), .o_Load_Error(er24));

  clock_counters_param #(.TICK_DIV(TD), .HOUR_MODE(12)) u_dut12 (
    .i_Clock(clk), .i_Reset(rst), .i_Run(run), .i_Adjust_Valid(adj),
    .i_Adjust_Field(fld), .i_Adjust_Down(dn), .i_Load(ld), .i_Load_Time(lt),
    .i_Load_PM(lpm), .o_Units_Sec(us12), .o_Tens_Sec(ts12), .o_Units_Min(um12),
    .o_Tens_Min(tm12), .o_Units_Hour(uh12), .o_Tens_Hour(th12), .o_PM(pm12),
    .o_Tick(tk12), .o_Day_Wrap(wr12), .o_Load_Error(er12));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = 24h instance, 1 = 12h instance.
  int   tod[2];
  int   presc[2];
  logic mt[2], mw[2], me[2];

  function automatic logic [19:0] P(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic load_ok(input logic [19:0] t, input int mi);
    int h;
    h = int'(t[19:18]) * 10 + int'(t[17:14]);
    if (t[17:14] > 4'd9 || t[13:11] > 3'd5 || t[10:7] > 4'd9 ||
        t[6:4] > 3'd5 || t[3:0] > 4'd9) return 1'b0;
    if (mi == 1) return (h >= 1 && h <= 12);
    return (h <= 23);
  endfunction

  function automatic int load_tod(input logic [19:0] t, input logic p, input int mi);
    int h, m, s;
    h = int'(t[19:18]) * 10 + int'(t[17:14]);
    m = int'(t[13:11]) * 10 + int'(t[10:7]);
    s = int'(t[6:4]) * 10 + int'(t[3:0]);
    if (mi == 1) h = (h % 12) + (p ? 12 : 0);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic int adjust_tod(input int t, input logic [1:0] f, input logic d, input int mi);
    int h, m, s, hd;
    logic pm;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    case (f)
      2'd0: s = d ? (s + 59) % 60 : (s + 1) % 60;
      2'd1: m = d ? (m + 59) % 60 : (m + 1) % 60;
      2'd2: begin
        if (mi == 0) begin
          h = d ? (h + 23) % 24 : (h + 1) % 24;
        end else begin
          pm = (h >= 12);
          hd = (h % 12 == 0) ? 12 : h % 12;
          hd = d ? (hd + 10) % 12 + 1 : hd % 12 + 1;
          h  = (hd % 12) + (pm ? 12 : 0);
        end
      end
      default: ;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] model_out(input int mi);
    int h, hd;
    logic pm;
    h  = tod[mi] / 3600;
    hd = (mi == 1) ? ((h % 12 == 0) ? 12 : h % 12) : h;
    pm = (mi == 1) && (h >= 12);
    return {P(hd, (tod[mi] / 60) % 60, tod[mi] % 60), pm, mt[mi], mw[mi], me[mi]};
  endfunction

  task automatic model_step(input int mi);
    mt[mi] = 1'b0; mw[mi] = 1'b0; me[mi] = 1'b0;
    if (rst) begin
      tod[mi] = 0; presc[mi] = 0;
    end else if (ld) begin
      if (load_ok(lt, mi)) begin
        tod[mi] = load_tod(lt, lpm, mi); presc[mi] = 0;
      end else begin
        me[mi] = 1'b1;
      end
    end else if (adj && fld != 2'd3) begin
      tod[mi] = adjust_tod(tod[mi], fld, dn, mi);
      if (fld == 2'd0) presc[mi] = 0;
      else if (run) presc[mi] = (presc[mi] + 1) % TD;
    end else if (run) begin
      if (presc[mi] == TD - 1) begin
        presc[mi] = 0;
        tod[mi] = (tod[mi] + 1) % 86400;
        mt[mi] = 1'b1;
        mw[mi] = (tod[mi] == 0);
      end else begin
        presc[mi] = presc[mi] + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got time=%h pm/tick/wrap/err=%b, expected time=%h pm/tick/wrap/err=%b",
               name, $time, got[23:4], got[3:0], exp[23:4], exp[3:0]);
    end
  endtask

  // One clock cycle: drive, clock, advance models, compare both instances.
  task automatic step(input logic r, input logic rn, input logic a, input logic [1:0] f,
                      input logic d, input logic l, input logic [19:0] t, input logic p);
    rst = r; run = rn; adj = a; fld = f; dn = d; ld = l; lt = t; lpm = p;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("model24", got24, model_out(0));
    check("model12", got12, model_out(1));
  endtask

  typedef struct {
    logic rst, run, adj; logic [1:0] fld; logic dn, ld; logic [19:0] lt; logic lpm;
    logic [19:0] e24, e12; logic pm12, tick, w24, w12, er24, er12;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input logic r, input logic rn, input logic a, input logic [1:0] f,
                         input logic d, input logic l, input logic [19:0] t, input logic p,
                         input logic [19:0] e24, input logic [19:0] e12, input logic pm12,
                         input logic tk, input logic w24, input logic w12,
                         input logic x24, input logic x12);
    vec_t v;
    v.rst = r; v.run = rn; v.adj = a; v.fld = f; v.dn = d; v.ld = l; v.lt = t; v.lpm = p;
    v.e24 = e24; v.e12 = e12; v.pm12 = pm12; v.tick = tk;
    v.w24 = w24; v.w12 = w12; v.er24 = x24; v.er12 = x12;
    vq.push_back(v);
  endtask

  initial begin
    logic [19:0] z, bad;
    vec_t v;
    z = 20'h0;
    rst = 1'b1; run = 1'b0; adj = 1'b0; fld = 2'd0; dn = 1'b0; ld = 1'b0; lt = z; lpm = 1'b0;

    // Reset, then 12 running cycles: ticks every 4th cycle up to 00:00:03.
    add_vec(1, 0, 0, 2'd0, 0, 0, z, 0, P(0, 0, 0), P(12, 0, 0), 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, P(0, 0, k / 4), P(12, 0, k / 4), 0, (k % 4 == 0), 0, 0, 0, 0);
    // 23:59:58 is legal only in 24h; 8 cycles later the 24h day wraps.
    add_vec(0, 1, 0, 2'd0, 0, 1, P(23, 59, 58), 0, P(23, 59, 58), P(12, 0, 3), 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, (k < 4) ? P(23, 59, 58) : (k < 8) ? P(23, 59, 59) : P(0, 0, 0),
              P(12, 0, 3 + k / 4), 0, (k % 4 == 0), (k == 8), 0, 0, 0);
    // 11:59:59 AM -> 12:00:00 PM without a day wrap.
    add_vec(0, 1, 0, 2'd0, 0, 1, P(11, 59, 59), 0, P(11, 59, 59), P(11, 59, 59), 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, (k < 4) ? P(11, 59, 59) : P(12, 0, 0),
              (k < 4) ? P(11, 59, 59) : P(12, 0, 0), (k == 4), (k == 4), 0, 0, 0, 0);
    // 12:59:59 PM -> 01:00:00 PM.
    add_vec(0, 1, 0, 2'd0, 0, 1, P(12, 59, 59), 1, P(12, 59, 59), P(12, 59, 59), 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, (k < 4) ? P(12, 59, 59) : P(13, 0, 0),
              (k < 4) ? P(12, 59, 59) : P(1, 0, 0), 1, (k == 4), 0, 0, 0, 0);
    // 11:59:59 PM -> 12:00:00 AM wraps the 12h day.
    add_vec(0, 1, 0, 2'd0, 0, 1, P(11, 59, 59), 1, P(11, 59, 59), P(11, 59, 59), 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, (k < 4) ? P(11, 59, 59) : P(12, 0, 0),
              (k < 4) ? P(11, 59, 59) : P(12, 0, 0), (k < 4), (k == 4), 0, (k == 4), 0, 0);
    // Adjusts: minute borrow-free down-step, second wrap without carry.
    add_vec(0, 0, 0, 2'd0, 0, 1, P(10, 0, 30), 0, P(10, 0, 30), P(10, 0, 30), 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 2'd1, 1, 0, z, 0, P(10, 59, 30), P(10, 59, 30), 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 2'd0, 0, 1, P(10, 20, 59), 0, P(10, 20, 59), P(10, 20, 59), 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 2'd0, 0, 0, z, 0, P(10, 20, 0), P(10, 20, 0), 0, 0, 0, 0, 0, 0);
    // Rejected loads leave the time alone.
    bad = P(10, 20, 0) | 20'hA;
    add_vec(0, 0, 0, 2'd0, 0, 1, P(24, 0, 0), 0, P(10, 20, 0), P(10, 20, 0), 0, 0, 0, 0, 1, 1);
    add_vec(0, 0, 0, 2'd0, 0, 1, bad, 0, P(10, 20, 0), P(10, 20, 0), 0, 0, 0, 0, 1, 1);
    // Load beats a simultaneous adjust; field 3 adjust is a no-op.
    add_vec(0, 0, 1, 2'd0, 0, 1, P(5, 6, 7), 0, P(5, 6, 7), P(5, 6, 7), 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 2'd3, 0, 0, z, 0, P(5, 6, 7), P(5, 6, 7), 0, 0, 0, 0, 0, 0);
    // Stopped for 20 cycles, then the prescaler resumes from 0.
    for (int k = 1; k <= 20; k++)
      add_vec(0, 0, 0, 2'd0, 0, 0, z, 0, P(5, 6, 7), P(5, 6, 7), 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, (k < 4) ? P(5, 6, 7) : P(5, 6, 8),
              (k < 4) ? P(5, 6, 7) : P(5, 6, 8), 0, (k == 4), 0, 0, 0, 0);
    // Reset mid-second: next tick exactly TD cycles after release.
    add_vec(1, 1, 0, 2'd0, 0, 0, z, 0, P(0, 0, 0), P(12, 0, 0), 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add_vec(0, 1, 0, 2'd0, 0, 0, z, 0, P(0, 0, k / 4), P(12, 0, k / 4), 0, (k == 4), 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      step(v.rst, v.run, v.adj, v.fld, v.dn, v.ld, v.lt, v.lpm);
      check("tbl24", got24, {v.e24, 1'b0, v.tick, v.w24, v.er24});
      check("tbl12", got12, {v.e12, v.pm12, v.tick, v.w12, v.er12});
    end

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [19:0] t;
      int hs;
      case ($urandom_range(0, 3))
        0: t = 20'($urandom);
        1: t = P($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        2: begin
          hs = $urandom_range(0, 2);
          t = P((hs == 0) ? 11 : (hs == 1) ? 12 : 23, 59, $urandom_range(55, 59));
        end
        default: t = P($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(50, 59));
      endcase
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, t, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
